tenv_usbtrver_sync: RTL and testbench

Parametrised USB transceiver model for the link-layer test environment. It drives the bidirectional D+/D- bus from the bench and samples the bus back through a configurable synchroniser and glitch filter. It decodes line state (SE0/J/K/SE1) and detects EOP, bus reset and suspend for the bench. It sits between the device-under-test bus pins and the bench's host-side driver and monitor.

---
 rtl/tenv_usbtrver_sync.sv | 140 ++++++++++++++
 tb/tb_tenv_usbtrver_sync.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tenv_usbtrver_sync.sv
// USB transceiver model for the link-layer test environment. It drives D+/D-
// from the bench and samples the bus back through a synchroniser and a glitch
// filter. It decodes the line state and flags EOP, bus reset and suspend.
module tenv_usbtrver_sync #(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned FILTER_LEN       = 3,
  parameter int unsigned LOW_SPEED        = 0,
  parameter int unsigned SE0_RESET_CYCLES = 16,
  parameter int unsigned SUSPEND_CYCLES   = 32
) (
  input  logic       sync_clk,
  input  logic       rstn,
  input  logic       sync_mode,
  input  logic       dinp,
  input  logic       dinn,
  input  logic       doe,
  output logic       doutp,
  output logic       doutn,
  output logic       doutdif,
  output logic [1:0] line_state,
  output logic       eop_det,
  output logic       usb_reset,
  output logic       usb_suspend,
  inout  wire        usb_dp,
  inout  wire        usb_dn
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned RCW = $clog2(SE0_RESET_CYCLES + 1);
  localparam int unsigned SCW = $clog2(SUSPEND_CYCLES + 1);
  localparam logic        J_P = (LOW_SPEED == 0) ? 1'b1 : 1'b0;
  localparam logic        J_N = ~J_P;

  // Bench-side tri-state drivers
  assign usb_dp = doe ? dinp : 1'bz;
  assign usb_dn = doe ? dinn : 1'bz;

  // Undriven lines settle at the idle (J) levels of the selected speed
  if (LOW_SPEED == 0) begin : g_fs_pull
    pullup   (usb_dp);
    pulldown (usb_dn);
  end else begin : g_ls_pull
    pulldown (usb_dp);
    pullup   (usb_dn);
  end

  logic                   bus_p, bus_n;
  logic [SYNC_STAGES-1:0] sync_p, sync_n;
  logic [SYNC_STAGES:0]   shin_p, shin_n;
  logic                   smp_p, smp_n, cand_p, cand_n;
  logic                   filt_p, filt_n, filt_p_d, filt_n_d;
  logic [FCW-1:0]         fcnt, fcnt_d;
  logic [RCW-1:0]         se0_cnt, se0_cnt_d;
  logic [SCW-1:0]         j_cnt, j_cnt_d;
  logic                   is_se0, is_j, eop_d;

  assign bus_p = usb_dp;
  assign bus_n = usb_dn;

  // The last synchroniser flop doubles as the filter candidate
  assign shin_p = {sync_p, bus_p};
  assign shin_n = {sync_n, bus_n};
  assign smp_p  = shin_p[SYNC_STAGES-1];
  assign smp_n  = shin_n[SYNC_STAGES-1];
  assign cand_p = sync_p[SYNC_STAGES-1];
  assign cand_n = sync_n[SYNC_STAGES-1];

  assign is_se0 = ({filt_p, filt_n} == 2'b00);
  assign is_j   = ({filt_p, filt_n} == {J_P, J_N});

  // Filter run length, filtered state, and line event counters
  always_comb begin
    fcnt_d    = FCW'(1);
    filt_p_d  = filt_p;
    filt_n_d  = filt_n;
    se0_cnt_d = '0;
    j_cnt_d   = '0;
    eop_d     = 1'b0;
    if ({smp_p, smp_n} == {cand_p, cand_n}) begin
      if (fcnt >= FCW'(FILTER_LEN)) fcnt_d = FCW'(FILTER_LEN);
      else                          fcnt_d = fcnt + FCW'(1);
    end
    if (fcnt_d == FCW'(FILTER_LEN)) begin
      filt_p_d = smp_p;
      filt_n_d = smp_n;
    end
    if (is_se0 && !doe) begin
      if (se0_cnt == RCW'(SE0_RESET_CYCLES)) se0_cnt_d = se0_cnt;
      else                                   se0_cnt_d = se0_cnt + RCW'(1);
    end
    if (is_j && !doe) begin
      if (j_cnt == SCW'(SUSPEND_CYCLES)) j_cnt_d = j_cnt;
      else                               j_cnt_d = j_cnt + SCW'(1);
    end
    if (is_se0 && !doe && ({filt_p_d, filt_n_d} == {J_P, J_N}) &&
        (se0_cnt >= RCW'(1)) && (se0_cnt <= RCW'(SE0_RESET_CYCLES - 1)))
      eop_d = 1'b1;
  end

  // State registers
  always_ff @(posedge sync_clk or negedge rstn) begin
    if (!rstn) begin
      sync_p  <= {SYNC_STAGES{J_P}};
      sync_n  <= {SYNC_STAGES{J_N}};
      filt_p  <= J_P;
      filt_n  <= J_N;
      fcnt    <= '0;
      se0_cnt <= '0;
      j_cnt   <= '0;
      eop_det <= 1'b0;
    end else begin
      sync_p  <= shin_p[SYNC_STAGES-1:0];
      sync_n  <= shin_n[SYNC_STAGES-1:0];
      filt_p  <= filt_p_d;
      filt_n  <= filt_n_d;
      fcnt    <= fcnt_d;
      se0_cnt <= se0_cnt_d;
      j_cnt   <= j_cnt_d;
      eop_det <= eop_d;
    end
  end

  // Line state decode and level flags; flags drop as soon as the state leaves
  always_comb begin
    line_state = 2'b10;
    if (is_se0)                                 line_state = 2'b00;
    else if ({filt_p, filt_n} == 2'b11)         line_state = 2'b11;
    else if (is_j)                              line_state = 2'b01;
    usb_reset   = is_se0 && (se0_cnt == RCW'(SE0_RESET_CYCLES));
    usb_suspend = is_j && (j_cnt == SCW'(SUSPEND_CYCLES));
  end

  // Received data: raw bus or filtered state
  always_comb begin
    doutp   = sync_mode ? filt_p : bus_p;
    doutn   = sync_mode ? filt_n : bus_n;
    doutdif = ~(~doutp & doutn);
  end

endmodule

// File: tb/tb_tenv_usbtrver_sync.sv
// Directed bench for tenv_usbtrver_sync: a full-speed instance with a
// device-side bus driver, plus a low-speed instance left idle.
module tb_tenv_usbtrver_sync;

  logic       sync_clk = 1'b0;
  logic       rstn, sync_mode, dinp, dinn, doe;
  logic       dev_oe, dev_p, dev_n;
  logic       doutp, doutn, doutdif, eop_det, usb_reset, usb_suspend;
  logic [1:0] line_state;
  wire        usb_dp, usb_dn;

  logic       ls_doe;
  logic       ls_doutp, ls_doutn, ls_doutdif, ls_eop, ls_reset, ls_suspend;
  logic [1:0] ls_line_state;
  wire        ls_dp, ls_dn;

  int total = 0;
  int bad   = 0;

  always #5 sync_clk = ~sync_clk;

  // Device-side driver sharing the bus with the model
  assign usb_dp = dev_oe ? dev_p : 1'bz;
  assign usb_dn = dev_oe ? dev_n : 1'bz;

  tenv_usbtrver_sync u_fs (
    .sync_clk(sync_clk), .rstn(rstn), .sync_mode(sync_mode),
    .dinp(dinp), .dinn(dinn), .doe(doe),
    .doutp(doutp), .doutn(doutn), .doutdif(doutdif), .line_state(line_state),
    .eop_det(eop_det), .usb_reset(usb_reset), .usb_suspend(usb_suspend),
    .usb_dp(usb_dp), .usb_dn(usb_dn)
  );

  tenv_usbtrver_sync #(.LOW_SPEED(1)) u_ls (
    .sync_clk(sync_clk), .rstn(rstn), .sync_mode(sync_mode),
    .dinp(dinp), .dinn(dinn), .doe(ls_doe),
    .doutp(ls_doutp), .doutn(ls_doutn), .doutdif(ls_doutdif), .line_state(ls_line_state),
    .eop_det(ls_eop), .usb_reset(ls_reset), .usb_suspend(ls_suspend),
    .usb_dp(ls_dp), .usb_dn(ls_dn)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge sync_clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; sync_mode = 1'b1; doe = 1'b0; dinp = 1'b1; dinn = 1'b0;
    dev_oe = 1'b0; dev_p = 1'b1; dev_n = 1'b0; ls_doe = 1'b0;
    tick(3);
    total++; if (line_state !== 2'b01) begin bad++; $display("FAIL reset_line_state got=%b exp=01", line_state); end
    total++; if ({eop_det, usb_reset, usb_suspend} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {eop_det, usb_reset, usb_suspend}); end
    total++; if ({doutp, doutn, doutdif} !== 3'b101) begin bad++; $display("FAIL reset_dout got=%b exp=101", {doutp, doutn, doutdif}); end
    rstn = 1'b1;
    tick(1);
    total++; if (line_state !== 2'b01) begin bad++; $display("FAIL post_reset_line_state got=%b exp=01", line_state); end
  endtask

  task automatic test_k_latency();
    logic [1:0] exp_ls;
    doe = 1'b1; dinp = 1'b0; dinn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      exp_ls = (k >= 4) ? 2'b10 : 2'b01;
      total++; if (line_state !== exp_ls) begin bad++; $display("FAIL k_latency edge=%0d got=%b exp=%b", k, line_state, exp_ls); end
    end
    total++; if (doutdif !== 1'b0) begin bad++; $display("FAIL k_doutdif got=%b exp=0", doutdif); end
    sync_mode = 1'b0; #1;
    total++; if ({doutp, doutn} !== 2'b01) begin bad++; $display("FAIL k_raw_dout got=%b exp=01", {doutp, doutn}); end
    sync_mode = 1'b1;
    dinp = 1'b1; dinn = 1'b0;
    tick(6);
    total++; if (line_state !== 2'b01) begin bad++; $display("FAIL k_back_to_j got=%b exp=01", line_state); end
  endtask

  task automatic test_glitch();
    dinp = 1'b0; dinn = 1'b1;
    tick(2);
    dinp = 1'b1; dinn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      total++; if (line_state !== 2'b01) begin bad++; $display("FAIL glitch cycle=%0d got=%b exp=01", k, line_state); end
      tick(1);
    end
  endtask

  task automatic test_eop();
    int pulses;
    int se0_seen;
    pulses = 0; se0_seen = 0;
    doe = 1'b0; dev_oe = 1'b1; dev_p = 1'b0; dev_n = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (eop_det === 1'b1) pulses++;
      if (line_state === 2'b00) se0_seen++;
      if (k == 4) begin dev_p = 1'b1; dev_n = 1'b0; end
      if (k == 6) dev_oe = 1'b0;
    end
    total++; if (se0_seen !== 4) begin bad++; $display("FAIL eop_se0_cycles got=%0d exp=4", se0_seen); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL eop_pulse_count got=%0d exp=1", pulses); end
    pulses = 0;
    doe = 1'b1; dinp = 1'b0; dinn = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (eop_det === 1'b1) pulses++;
      if (k == 4) begin dinp = 1'b1; dinn = 1'b0; end
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL eop_masked_count got=%0d exp=0", pulses); end
  endtask

  task automatic test_bus_reset_suspend();
    logic exp_r, exp_s;
    int   eops;
    eops = 0;
    doe = 1'b0; dev_oe = 1'b1; dev_p = 1'b0; dev_n = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick(1);
      exp_r = (k >= 20) && (k <= 27);
      exp_s = (k >= 60);
      if (eop_det === 1'b1) eops++;
      total++; if (usb_reset !== exp_r) begin bad++; $display("FAIL bus_reset edge=%0d got=%b exp=%b", k, usb_reset, exp_r); end
      if (k >= 56) begin
        total++; if (usb_suspend !== exp_s) begin bad++; $display("FAIL suspend edge=%0d got=%b exp=%b", k, usb_suspend, exp_s); end
      end
      if (k == 24) begin dev_p = 1'b1; dev_n = 1'b0; end
      if (k == 30) dev_oe = 1'b0;
    end
    total++; if (eops !== 0) begin bad++; $display("FAIL reset_no_eop got=%0d exp=0", eops); end
    doe = 1'b1; dinp = 1'b1; dinn = 1'b0;
    tick(1);
    total++; if ({usb_reset, usb_suspend} !== 2'b00) begin bad++; $display("FAIL suspend_doe_clear got=%b exp=00", {usb_reset, usb_suspend}); end
  endtask

  task automatic test_doe_clears_reset();
    doe = 1'b0; dev_oe = 1'b1; dev_p = 1'b0; dev_n = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick(1);
      if (k == 19) begin
        total++; if (usb_reset !== 1'b0) begin bad++; $display("FAIL doe_pre_reset got=%b exp=0", usb_reset); end
      end
      if (k == 20) begin
        total++; if (usb_reset !== 1'b1) begin bad++; $display("FAIL doe_reset_rise got=%b exp=1", usb_reset); end
      end
    end
    dev_oe = 1'b0; doe = 1'b1; dinp = 1'b0; dinn = 1'b0;
    tick(1);
    total++; if (usb_reset !== 1'b0) begin bad++; $display("FAIL doe_reset_clear got=%b exp=0", usb_reset); end
    total++; if (line_state !== 2'b00) begin bad++; $display("FAIL doe_echo_se0 got=%b exp=00", line_state); end
    dinp = 1'b1; dinn = 1'b0;
    tick(8);
  endtask

  task automatic test_reset_mid();
    doe = 1'b0; dev_oe = 1'b1; dev_p = 1'b0; dev_n = 1'b0;
    tick(12);
    total++; if (line_state !== 2'b00) begin bad++; $display("FAIL mid_pre_se0 got=%b exp=00", line_state); end
    rstn = 1'b0; #1;
    total++; if ({line_state, usb_reset} !== 3'b010) begin bad++; $display("FAIL mid_async_clear got=%b exp=010", {line_state, usb_reset}); end
    tick(2);
    rstn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 19) begin
        total++; if (usb_reset !== 1'b0) begin bad++; $display("FAIL mid_restart_early got=%b exp=0", usb_reset); end
      end
      if (k == 20) begin
        total++; if (usb_reset !== 1'b1) begin bad++; $display("FAIL mid_restart_rise got=%b exp=1", usb_reset); end
      end
    end
    dev_p = 1'b1; dev_n = 1'b0;
    tick(2);
    dev_oe = 1'b0;
  endtask

  task automatic test_low_speed();
    tick(40);
    sync_mode = 1'b1; #1;
    total++; if (ls_line_state !== 2'b01) begin bad++; $display("FAIL ls_line_state got=%b exp=01", ls_line_state); end
    total++; if ({ls_doutp, ls_doutn} !== 2'b01) begin bad++; $display("FAIL ls_filtered_dout got=%b exp=01", {ls_doutp, ls_doutn}); end
    total++; if (ls_suspend !== 1'b1) begin bad++; $display("FAIL ls_suspend got=%b exp=1", ls_suspend); end
    sync_mode = 1'b0; #1;
    total++; if ({ls_doutp, ls_doutn, ls_doutdif} !== 3'b010) begin bad++; $display("FAIL ls_raw_dout got=%b exp=010", {ls_doutp, ls_doutn, ls_doutdif}); end
    total++; if ({ls_eop, ls_reset} !== 2'b00) begin bad++; $display("FAIL ls_flags got=%b exp=00", {ls_eop, ls_reset}); end
    sync_mode = 1'b1;
  endtask

  initial begin
    test_reset();
    test_k_latency();
    test_glitch();
    test_eop();
    test_bus_reset_suspend();
    test_doe_clears_reset();
    test_reset_mid();
    test_low_speed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
